// File: rtl/typing_round_ctrl.sv
// typing_round_ctrl
// Round controller for a PS/2 digit-typing reaction game. Each round picks a
// pseudo-random digit from a free-running LFSR, shows it on the 7-segment
// display and waits for the player to type it. A correct make code scores a
// hit; a wrong make code or running out of time scores a miss. After the
// result has been shown for a while the next round starts, until ROUNDS rounds
// have been played.
//
// Ports
//   clk        : single clock (50 MHz domain shared with the PS/2 receiver)
//   rst_n      : synchronous active-low reset
//   start      : one-cycle pulse, begins a game from IDLE or DONE
//   keycode    : last two PS/2 bytes, [7:0] is the newest
//   key_valid  : one-cycle pulse when keycode updates
//   disp_value : four hex nibbles for the 7-segment driver
//   hit        : one-cycle pulse on a correct key
//   miss       : one-cycle pulse on a wrong key or timeout
//   score      : hits in the current/last game
//   done       : high while the game is over

module typing_round_ctrl #(
  parameter int unsigned ROUNDS         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned RESULT_CYCLES  = 25_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] keycode,
  input  logic        key_valid,
  output logic [15:0] disp_value,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  score,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    WAIT_KEY,
    RESULT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [3:0]  target;
  logic [3:0]  pick_target;
  logic [7:0]  round;
  logic [31:0] wait_cnt;
  logic [31:0] hold_cnt;
  logic        armed;
  logic        last_hit;

  logic        is_make;
  logic        is_release;
  logic        accepted;
  logic        code_match;
  logic        timed_out;
  logic        hold_over;
  logic        last_round;

  // Set-2 make codes of the digit keys on the main row.
  function automatic logic [7:0] digit_code(input logic [3:0] d);
    logic [7:0] code;
    code = 8'h00;
    case (d)
      4'd0: code = 8'h45;
      4'd1: code = 8'h16;
      4'd2: code = 8'h1E;
      4'd3: code = 8'h26;
      4'd4: code = 8'h25;
      4'd5: code = 8'h2E;
      4'd6: code = 8'h36;
      4'd7: code = 8'h3D;
      4'd8: code = 8'h3E;
      4'd9: code = 8'h46;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  // A byte pair containing F0 in either slot is part of a break sequence, so
  // only pairs free of F0 count as fresh key presses.
  assign is_make    = key_valid && (keycode[7:0] != 8'hF0) && (keycode[15:8] != 8'hF0);
  assign is_release = key_valid && !is_make;
  assign accepted   = is_make && armed && (state == WAIT_KEY);
  assign code_match = (keycode[7:0] == digit_code(target));
  assign timed_out  = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign hold_over  = (hold_cnt == 32'(RESULT_CYCLES - 1));
  assign last_round = ((round + 8'd1) == 8'(ROUNDS));

  // Fold the 0..15 LFSR nibble into 0..9 (10..15 map onto 0..5).
  assign pick_target = (lfsr[3:0] < 4'd10) ? lfsr[3:0] : (lfsr[3:0] - 4'd10);

  // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Next-state logic. An accepted make takes priority over a timeout in the
  // same cycle because both simply lead to RESULT; the judging is elsewhere.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = PICK;
      PICK:       state_next = WAIT_KEY;
      WAIT_KEY:   if (accepted || timed_out) state_next = RESULT;
      RESULT:     if (hold_over) state_next = last_round ? DONE : PICK;
      default:    state_next = IDLE;
    endcase
  end

  // Game datapath: target latch, timers, round/score bookkeeping and the
  // registered hit/miss pulses raised on the edge into RESULT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      target   <= 4'd0;
      round    <= 8'd0;
      score    <= 8'd0;
      wait_cnt <= 32'd0;
      hold_cnt <= 32'd0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      last_hit <= 1'b0;
    end else begin
      state <= state_next;
      lfsr  <= lfsr_next;
      hit   <= 1'b0;
      miss  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            score <= 8'd0;
            round <= 8'd0;
          end
        end
        PICK: begin
          target   <= pick_target;
          wait_cnt <= 32'd0;
        end
        WAIT_KEY: begin
          if (accepted) begin
            hit      <= code_match;
            miss     <= !code_match;
            last_hit <= code_match;
            hold_cnt <= 32'd0;
            if (code_match && (score != 8'hFF)) score <= score + 8'd1;
          end else if (timed_out) begin
            miss     <= 1'b1;
            last_hit <= 1'b0;
            hold_cnt <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        RESULT: begin
          if (hold_over) round <= round + 8'd1;
          else           hold_cnt <= hold_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Typematic filter: a held key keeps resending its make code, so a make is
  // only taken once per press. Releases and the start of every round re-arm.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed <= 1'b1;
    end else if ((state_next == PICK && state != PICK) || is_release) begin
      armed <= 1'b1;
    end else if (accepted) begin
      armed <= 1'b0;
    end
  end

  // Display mux. During PICK the freshly folded LFSR digit is shown so the
  // display never flashes the previous round's target.
  always_comb begin
    disp_value = 16'h0000;
    case (state)
      IDLE:     disp_value = 16'h0000;
      PICK:     disp_value = {pick_target, round[3:0], score};
      WAIT_KEY: disp_value = {target, round[3:0], score};
      RESULT:   disp_value = {(last_hit ? 4'hA : 4'hE), round[3:0], score};
      DONE:     disp_value = {8'h00, score};
      default:  disp_value = 16'h0000;
    endcase
  end

  assign done = (state == DONE);

endmodule
